// File: rtl/check_origin_axis_if.sv
// AXI-stream link carrying origin-pattern frames into the frame checker.
// Clock and reset travel with the stream so the checker needs no extra ports.
interface check_origin_axis_if #(
  parameter int unsigned DATA_W = 32
) (
  input logic aclk,
  input logic aresetn
);
  logic [DATA_W-1:0]   tdata;
  logic                tvalid;
  logic                tlast;
  logic                aclken;
  logic                tready;
  logic [3:0]          tuser;
  logic [DATA_W/8-1:0] tkeep;

  modport master (
    input  aclk, aresetn, tready,
    output tdata, tvalid, tlast, aclken, tuser, tkeep
  );

  modport slave (
    input  aclk, aresetn, tdata, tvalid, tlast, aclken, tuser, tkeep,
    output tready
  );
endinterface

// File: rtl/check_origin_axis.sv
// Frame checker for the origin-pattern generator: verifies data pattern and
// tlast position per armed frame, and keeps pass/fail statistics.
module check_origin_axis #(
  parameter string       MODE       = "RANGE",
  parameter string       READY_MODE = "ALWAYS",
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter logic [31:0] WATCHDOG   = 32'd1024,
  parameter int unsigned DATA_W     = 32
) (
  check_origin_axis_if.slave axis_in,
  input  logic               i_enable,
  input  logic [31:0]        i_start,
  input  logic [31:0]        i_length,
  output logic               o_ready,
  output logic               o_done,
  output logic               o_pass,
  output logic               o_err_data,
  output logic               o_err_last,
  output logic               o_err_timeout,
  output logic [31:0]        o_frame_cnt,
  output logic [31:0]        o_fail_cnt,
  output logic [31:0]        o_first_err_beat
);
  localparam bit L_RANGE = (MODE == "RANGE");
  localparam bit L_LFSR  = (READY_MODE == "LFSR");

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  // Fibonacci LFSR, taps 16,14,13,11.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  state_t      r_state;
  logic        r_ready, r_tready, r_done, r_pass;
  logic        r_err_data, r_err_last, r_err_timeout;
  logic [31:0] r_frame_cnt, r_fail_cnt, r_first_err_beat;
  logic [31:0] r_exp, r_lock_len, r_beat_cnt, r_wd_cnt;
  logic [15:0] r_lfsr;

  state_t      w_nstate;
  logic        w_hs, w_arm, w_mismatch, w_any_err, w_unused;
  logic        w_err_data_nxt, w_err_last_nxt, w_err_timeout_nxt;
  logic [31:0] w_wd_nxt;
  logic [15:0] w_lfsr_nxt;

  assign w_hs       = (r_state == S_CHECK) && axis_in.tvalid && r_tready && axis_in.aclken;
  assign w_arm      = (r_state == S_IDLE) && i_enable && r_ready;
  assign w_mismatch = (axis_in.tdata != r_exp[DATA_W-1:0]);
  assign w_lfsr_nxt = (r_state == S_CHECK) ? lfsr_step(r_lfsr) : r_lfsr;
  assign w_any_err  = w_err_data_nxt || w_err_last_nxt || w_err_timeout_nxt;
  assign w_unused   = ^{axis_in.tuser, axis_in.tkeep};

  // Next state plus the per-frame error flags as they stand after this cycle.
  always_comb begin
    w_nstate          = r_state;
    w_err_data_nxt    = r_err_data;
    w_err_last_nxt    = r_err_last;
    w_err_timeout_nxt = r_err_timeout;
    w_wd_nxt          = r_wd_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_arm) w_nstate = S_CHECK;
        else       w_nstate = S_IDLE;
      end
      S_CHECK: begin
        if (w_hs) begin
          w_wd_nxt = 32'd0;
          if (w_mismatch) w_err_data_nxt = 1'b1;
          else            w_err_data_nxt = r_err_data;
          // Early tlast and a missing tlast on the final beat both count.
          if (axis_in.tlast && (r_beat_cnt < r_lock_len - 32'd1))        w_err_last_nxt = 1'b1;
          else if (!axis_in.tlast && (r_beat_cnt == r_lock_len - 32'd1)) w_err_last_nxt = 1'b1;
          else                                                           w_err_last_nxt = r_err_last;
          if (axis_in.tlast) w_nstate = S_REPORT;
          else               w_nstate = S_CHECK;
        end else if ((WATCHDOG != 32'd0) && (r_wd_cnt + 32'd1 == WATCHDOG)) begin
          w_wd_nxt          = r_wd_cnt + 32'd1;
          w_err_timeout_nxt = 1'b1;
          w_nstate          = S_REPORT;
        end else begin
          w_wd_nxt = r_wd_cnt + 32'd1;
          w_nstate = S_CHECK;
        end
      end
      S_REPORT: w_nstate = S_IDLE;
      default:  w_nstate = S_IDLE;
    endcase
  end

  // Frame FSM with all outputs registered.
  always_ff @(posedge axis_in.aclk or negedge axis_in.aresetn) begin
    if (!axis_in.aresetn) begin
      r_state          <= S_IDLE;
      r_ready          <= 1'b0;
      r_tready         <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_err_data       <= 1'b0;
      r_err_last       <= 1'b0;
      r_err_timeout    <= 1'b0;
      r_frame_cnt      <= 32'd0;
      r_fail_cnt       <= 32'd0;
      r_first_err_beat <= 32'hFFFF_FFFF;
      r_exp            <= 32'd0;
      r_lock_len       <= 32'd1;
      r_beat_cnt       <= 32'd0;
      r_wd_cnt         <= 32'd0;
      r_lfsr           <= LFSR_SEED;
    end else begin
      r_state  <= w_nstate;
      r_ready  <= (w_nstate == S_IDLE);
      r_tready <= (w_nstate == S_CHECK) && (!L_LFSR || w_lfsr_nxt[0]);
      r_done   <= (w_nstate == S_REPORT);
      r_lfsr   <= w_lfsr_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_arm) begin
            r_exp            <= i_start;
            r_lock_len       <= (i_length == 32'd0) ? 32'd1 : i_length;
            r_beat_cnt       <= 32'd0;
            r_err_data       <= 1'b0;
            r_err_last       <= 1'b0;
            r_err_timeout    <= 1'b0;
            r_pass           <= 1'b0;
            r_wd_cnt         <= 32'd0;
            r_first_err_beat <= 32'hFFFF_FFFF;
          end
        end
        S_CHECK: begin
          r_err_data    <= w_err_data_nxt;
          r_err_last    <= w_err_last_nxt;
          r_err_timeout <= w_err_timeout_nxt;
          r_wd_cnt      <= w_wd_nxt;
          if (w_hs) begin
            if (L_RANGE) r_exp <= r_exp + 32'd1;
            if (r_beat_cnt != 32'hFFFF_FFFF) r_beat_cnt <= r_beat_cnt + 32'd1;
            if (w_mismatch && !r_err_data) r_first_err_beat <= r_beat_cnt;
          end
          if (w_nstate == S_REPORT) begin
            r_pass      <= !w_any_err;
            r_frame_cnt <= r_frame_cnt + 32'd1;
            if (w_any_err) r_fail_cnt <= r_fail_cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign axis_in.tready   = r_tready;
  assign o_ready          = r_ready;
  assign o_done           = r_done;
  assign o_pass           = r_pass;
  assign o_err_data       = r_err_data;
  assign o_err_last       = r_err_last;
  assign o_err_timeout    = r_err_timeout;
  assign o_frame_cnt      = r_frame_cnt;
  assign o_fail_cnt       = r_fail_cnt;
  assign o_first_err_beat = r_first_err_beat;
endmodule

// File: tb/tb_check_origin_axis.sv
// Bench for check_origin_axis: three checker variants (RANGE/ALWAYS, RANGE/LFSR,
// CONST/ALWAYS) driven with directed and random frames against a frame-level model.
module tb_check_origin_axis;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        en, tv, tl, ce;
  logic [31:0] st, ln, td;
  int          sel;
  int          n_chk = 0;
  int          n_ok  = 0;
  int unsigned m_frames[3];
  int unsigned m_fails[3];
  bit          early_done, seen_tr0, seen_tr1;

  logic        rdy[3], dn[3], ps[3], ed[3], el[3], et[3];
  logic [31:0] fc[3], fl[3], feb[3];

  check_origin_axis_if #(.DATA_W(32)) if0 (.aclk(clk), .aresetn(rst_n));
  check_origin_axis_if #(.DATA_W(32)) if1 (.aclk(clk), .aresetn(rst_n));
  check_origin_axis_if #(.DATA_W(32)) if2 (.aclk(clk), .aresetn(rst_n));

  assign if0.tdata = td; assign if0.tvalid = tv && (sel == 0); assign if0.tlast = tl;
  assign if0.aclken = ce; assign if0.tuser = 4'd0; assign if0.tkeep = 4'hF;
  assign if1.tdata = td; assign if1.tvalid = tv && (sel == 1); assign if1.tlast = tl;
  assign if1.aclken = ce; assign if1.tuser = 4'd0; assign if1.tkeep = 4'hF;
  assign if2.tdata = td; assign if2.tvalid = tv && (sel == 2); assign if2.tlast = tl;
  assign if2.aclken = ce; assign if2.tuser = 4'd0; assign if2.tkeep = 4'hF;

  check_origin_axis #(.MODE("RANGE"), .READY_MODE("ALWAYS"), .WATCHDOG(32'd64)) u_dut0 (
    .axis_in(if0), .i_enable(en && (sel == 0)), .i_start(st), .i_length(ln),
    .o_ready(rdy[0]), .o_done(dn[0]), .o_pass(ps[0]), .o_err_data(ed[0]),
    .o_err_last(el[0]), .o_err_timeout(et[0]), .o_frame_cnt(fc[0]),
    .o_fail_cnt(fl[0]), .o_first_err_beat(feb[0]));

  check_origin_axis #(.MODE("RANGE"), .READY_MODE("LFSR"), .WATCHDOG(32'd16)) u_dut1 (
    .axis_in(if1), .i_enable(en && (sel == 1)), .i_start(st), .i_length(ln),
    .o_ready(rdy[1]), .o_done(dn[1]), .o_pass(ps[1]), .o_err_data(ed[1]),
    .o_err_last(el[1]), .o_err_timeout(et[1]), .o_frame_cnt(fc[1]),
    .o_fail_cnt(fl[1]), .o_first_err_beat(feb[1]));

  check_origin_axis #(.MODE("CONST"), .READY_MODE("ALWAYS"), .WATCHDOG(32'd64)) u_dut2 (
    .axis_in(if2), .i_enable(en && (sel == 2)), .i_start(st), .i_length(ln),
    .o_ready(rdy[2]), .o_done(dn[2]), .o_pass(ps[2]), .o_err_data(ed[2]),
    .o_err_last(el[2]), .o_err_timeout(et[2]), .o_frame_cnt(fc[2]),
    .o_fail_cnt(fl[2]), .o_first_err_beat(feb[2]));

  function automatic logic tready_of(input int d);
    case (d)
      0:       return if0.tready;
      1:       return if1.tready;
      default: return if2.tready;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_reset_vals(input int d);
    check_eq("rst_ready", rdy[d], 1'b0);
    check_eq("rst_tready", tready_of(d), 1'b0);
    check_eq("rst_done", dn[d], 1'b0);
    check_eq("rst_pass", ps[d], 1'b0);
    check_eq("rst_errs", {ed[d], el[d], et[d]}, 3'd0);
    check_eq("rst_frame_cnt", fc[d], 32'd0);
    check_eq("rst_fail_cnt", fl[d], 32'd0);
    check_eq("rst_first_err", feb[d], 32'hFFFF_FFFF);
  endtask

  task automatic arm(input int d, input logic [31:0] s, input logic [31:0] l);
    bit ok = 0;
    for (int c = 0; c < 20; c++) begin
      if (rdy[d]) begin ok = 1; break; end
      @(negedge clk);
    end
    check_eq("arm_ready", ok, 1'b1);
    en = 1'b1; st = s; ln = l;
    @(posedge clk); @(negedge clk);
    en = 1'b0; st = $urandom; ln = $urandom;
    check_eq("ready_drop", rdy[d], 1'b0);
  endtask

  // Present one beat until it is accepted; returns at the negedge after the handshake edge.
  task automatic send_beat(input int d, input logic [31:0] data, input bit last,
                           input bit bub, output bit ok);
    bit hs;
    ok = 0; td = data; tl = last;
    for (int c = 0; c < 200; c++) begin
      if (dn[d]) early_done = 1;
      tv = bub ? ($urandom_range(0, 3) != 0) : 1'b1;
      ce = bub ? ($urandom_range(0, 4) != 0) : 1'b1;
      en = (bub && !last) ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      if (d == 1) begin
        if (tready_of(d)) seen_tr1 = 1; else seen_tr0 = 1;
      end
      hs = tv && ce && tready_of(d);
      @(posedge clk); @(negedge clk);
      if (hs) begin ok = 1; break; end
    end
    tv = 1'b0;
    if (!ok) check_eq("beat_handshake", 1'b0, 1'b1);
  endtask

  task automatic run_frame(input int d, input logic [31:0] s, input logic [31:0] l,
                           input int tlast_at, input int corrupt_at,
                           input logic [31:0] cval, input bit stall);
    logic [31:0] lock, exp_d, data, m_feb;
    bit m_ed, m_el, m_et, ok, m_pass;
    int cnt;
    sel = d; early_done = 0;
    lock = (l == 32'd0) ? 32'd1 : l;
    m_ed = 0; m_el = 0; m_et = 0; m_feb = 32'hFFFF_FFFF;
    arm(d, s, l);
    if (stall) begin
      tv = 1'b0; m_et = 1; cnt = 1;
      while (!dn[d] && cnt < 100) begin @(negedge clk); cnt++; end
      check_eq("timeout_latency", cnt, 32'd17);
    end else begin
      for (int i = 0; i <= tlast_at; i++) begin
        exp_d = (d != 2) ? s + 32'(i) : s;
        data  = (i == corrupt_at) ? cval : exp_d;
        if (data != exp_d && !m_ed) begin m_ed = 1; m_feb = 32'(i); end
        if (i == tlast_at && 32'(i) < lock - 32'd1) m_el = 1;
        if (32'(i) == lock - 32'd1 && i != tlast_at) m_el = 1;
        send_beat(d, data, i == tlast_at, d != 1, ok);
        if (!ok) break;
      end
      check_eq("no_early_done", early_done, 1'b0);
    end
    m_pass = !(m_ed || m_el || m_et);
    m_frames[d]++;
    if (!m_pass) m_fails[d]++;
    check_eq("done", dn[d], 1'b1);
    check_eq("pass", ps[d], m_pass);
    check_eq("err_data", ed[d], m_ed);
    check_eq("err_last", el[d], m_el);
    check_eq("err_timeout", et[d], m_et);
    check_eq("first_err_beat", feb[d], m_feb);
    check_eq("frame_cnt", fc[d], m_frames[d]);
    check_eq("fail_cnt", fl[d], m_fails[d]);
    check_eq("tready_report", tready_of(d), 1'b0);
    @(negedge clk);
    check_eq("done_pulse", dn[d], 1'b0);
    check_eq("pass_hold", ps[d], m_pass);
  endtask

  initial begin
    bit ok;
    int d, len, tla, cat;
    rst_n = 1'b0; en = 1'b0; tv = 1'b0; tl = 1'b0; ce = 1'b1;
    st = 32'd0; ln = 32'd0; td = 32'd0; sel = 0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) check_reset_vals(k);
    rst_n = 1'b1;
    #1 check_eq("ready_after_release", rdy[0], 1'b0);
    @(negedge clk);
    check_eq("ready_rise", rdy[0], 1'b1);

    run_frame(0, 32'd100, 32'd8, 7, -1, 32'd0, 0);
    run_frame(0, 32'd5, 32'd1, 0, -1, 32'd0, 0);
    run_frame(0, 32'd5, 32'd0, 0, -1, 32'd0, 0);
    run_frame(0, 32'd0, 32'd6, 5, 3, 32'd99, 0);
    run_frame(0, 32'd0, 32'd6, 3, -1, 32'd0, 0);
    run_frame(0, 32'd0, 32'd6, 8, -1, 32'd0, 0);
    run_frame(2, 32'd7, 32'd5, 4, -1, 32'd0, 0);
    run_frame(2, 32'hDEAD, 32'd3, 2, 1, 32'hDEAE, 0);
    run_frame(1, 32'hFFFF_FFFE, 32'd4, 3, -1, 32'd0, 0);
    run_frame(1, 32'd0, 32'd4, 3, -1, 32'd0, 1);

    for (int f = 0; f < 30; f++) begin
      d   = $urandom_range(0, 2);
      len = $urandom_range(0, 10);
      tla = ($urandom_range(0, 9) < 7) ? ((len == 0) ? 0 : len - 1)
                                        : $urandom_range(0, ((len == 0) ? 1 : len) + 2);
      cat = ($urandom_range(0, 9) < 3) ? $urandom_range(0, tla) : -1;
      run_frame(d, $urandom, 32'(len), tla, cat, $urandom, 0);
    end

    // Reset in the middle of a frame: everything returns to reset values, nothing reported.
    sel = 0;
    arm(0, 32'd0, 32'd8);
    send_beat(0, 32'd0, 1'b0, 1'b0, ok);
    send_beat(0, 32'd1, 1'b0, 1'b0, ok);
    tv = 1'b1; td = 32'd2; tl = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) check_reset_vals(k);
    for (int k = 0; k < 3; k++) begin m_frames[k] = 0; m_fails[k] = 0; end
    tv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_eq("ready_after_rerelease", rdy[0], 1'b0);
    check_eq("no_done_after_reset", dn[0], 1'b0);
    @(negedge clk);
    check_eq("ready_rise_again", rdy[0], 1'b1);
    run_frame(0, 32'd40, 32'd8, 7, -1, 32'd0, 0);

    check_eq("lfsr_tready_low_seen", seen_tr0, 1'b1);
    check_eq("lfsr_tready_high_seen", seen_tr1, 1'b1);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule
